// File: rtl/wrr_bank_scheduler_if.sv
// Consumer/kernel bundle for the weighted round-robin bank scheduler.
// The master side drives requests, weights and stalls; the slave side grants.
interface wrr_bank_scheduler_if #(
    parameter int ADDR_WIDTH   = 4,
    parameter int VALUE_WIDTH  = 8,
    parameter int NCONSUMERS   = 4,
    parameter int NBANKS       = 2,
    parameter int NPORTS       = 1,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int BSEL      = $clog2(NBANKS);
    localparam int LADDR     = ADDR_WIDTH - BSEL;
    localparam int IDW       = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;
    localparam int NKERNELS  = NBANKS * NPORTS;
    localparam int OUT_WIDTH = 2 + LADDR + VALUE_WIDTH;

    logic [NCONSUMERS-1:0]                   req_valid;
    logic [NCONSUMERS-1:0][ADDR_WIDTH-1:0]   req_addr;
    logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]  req_value;
    logic [NCONSUMERS-1:0]                   req_we;
    logic [NCONSUMERS-1:0]                   req_ready;
    logic [NCONSUMERS-1:0][WEIGHT_WIDTH-1:0] weight;
    logic [NBANKS-1:0]                       bank_stall;
    logic [NKERNELS-1:0][OUT_WIDTH-1:0]      out;
    logic [NKERNELS-1:0][IDW-1:0]            out_id;

    modport master (
        output req_valid, req_addr, req_value, req_we,
        output weight, bank_stall,
        input  req_ready, out, out_id
    );

    modport slave (
        input  req_valid, req_addr, req_value, req_we,
        input  weight, bank_stall,
        output req_ready, out, out_id
    );
endinterface

// File: rtl/wrr_bank_scheduler.sv
// Weighted round-robin scheduler mapping consumer requests onto banked
// PLM kernels, NPORTS grants per bank per cycle, registered outputs.
module wrr_bank_scheduler #(
    parameter int ADDR_WIDTH   = 4,
    parameter int VALUE_WIDTH  = 8,
    parameter int NCONSUMERS   = 4,
    parameter int NBANKS       = 2,
    parameter int NPORTS       = 1,
    parameter int WEIGHT_WIDTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    wrr_bank_scheduler_if.slave bus
);
    localparam int BSEL      = $clog2(NBANKS);
    localparam int BW        = (BSEL > 0) ? BSEL : 1;
    localparam int LADDR     = ADDR_WIDTH - BSEL;
    localparam int IDW       = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;
    localparam int NKERNELS  = NBANKS * NPORTS;
    localparam int OUT_WIDTH = 2 + LADDR + VALUE_WIDTH;

    logic [IDW-1:0]          ptr   [NBANKS];
    logic [WEIGHT_WIDTH-1:0] cnt   [NBANKS];
    logic [IDW-1:0]          ptr_d [NBANKS];
    logic [WEIGHT_WIDTH-1:0] cnt_d [NBANKS];

    logic [NCONSUMERS-1:0]            grant;
    logic [NKERNELS-1:0]              kval;
    logic [IDW-1:0]                   kid [NKERNELS];
    logic [NCONSUMERS-1:0][BW-1:0]    cbank;
    logic [NCONSUMERS-1:0][LADDR-1:0] claddr;

    logic [NKERNELS-1:0][OUT_WIDTH-1:0] out_q;
    logic [NKERNELS-1:0][IDW-1:0]       id_q;

    int                      n;
    int                      idx;
    logic                    hit;
    logic [IDW-1:0]          last;
    logic [WEIGHT_WIDTH-1:0] wm1;

    // Low address bits select the bank, the rest is the bank-local address.
    for (genvar c = 0; c < NCONSUMERS; c++) begin : g_split
        if (BSEL > 0) begin : g_banked
            assign cbank[c]  = bus.req_addr[c][BW-1:0];
            assign claddr[c] = bus.req_addr[c][ADDR_WIDTH-1:ADDR_WIDTH-LADDR];
        end else begin : g_flat
            assign cbank[c]  = '0;
            assign claddr[c] = bus.req_addr[c][LADDR-1:0];
        end
    end

    always_comb begin
        grant = '0;
        kval  = '0;
        ptr_d = ptr;
        cnt_d = cnt;
        n     = 0;
        idx   = 0;
        hit   = 1'b0;
        last  = '0;
        wm1   = '0;
        for (int k = 0; k < NKERNELS; k++) kid[k] = '0;
        for (int b = 0; b < NBANKS; b++) begin
            n    = 0;
            hit  = 1'b0;
            last = ptr[b];
            for (int i = 0; i < NCONSUMERS; i++) begin
                idx = int'(ptr[b]) + i;
                if (idx >= NCONSUMERS) idx = idx - NCONSUMERS;
                if (!bus.bank_stall[b] && bus.req_valid[idx] &&
                    int'(cbank[idx]) == b && n < NPORTS) begin
                    grant[idx]         = 1'b1;
                    kval[b*NPORTS + n] = 1'b1;
                    kid[b*NPORTS + n]  = IDW'(idx);
                    last               = IDW'(idx);
                    if (i == 0) hit = 1'b1;
                    n = n + 1;
                end
            end
            // cnt+1 < max(w,1) rewritten as cnt < max(w,1)-1 to avoid overflow
            wm1 = (bus.weight[ptr[b]] == '0) ? '0 : bus.weight[ptr[b]] - 1'b1;
            if (hit && cnt[b] < wm1) begin
                cnt_d[b] = cnt[b] + 1'b1;
            end else if (n > 0) begin
                ptr_d[b] = (int'(last) == NCONSUMERS - 1) ? '0
                                                           : IDW'(int'(last) + 1);
                cnt_d[b] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NBANKS; b++) begin
                ptr[b] <= '0;
                cnt[b] <= '0;
            end
            out_q <= '0;
            id_q  <= '0;
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                ptr[b] <= ptr_d[b];
                cnt[b] <= cnt_d[b];
            end
            for (int k = 0; k < NKERNELS; k++) begin
                if (kval[k]) begin
                    out_q[k] <= {1'b1, bus.req_we[kid[k]],
                                 claddr[kid[k]], bus.req_value[kid[k]]};
                    id_q[k]  <= kid[k];
                end else begin
                    out_q[k][OUT_WIDTH-1] <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready = grant & {NCONSUMERS{reset}};
    assign bus.out       = out_q;
    assign bus.out_id    = id_q;
endmodule

// File: tb/tb_wrr_bank_scheduler.sv
// Directed bench for wrr_bank_scheduler: one NPORTS=1 and one NPORTS=2
// instance, expected values hand-computed from the arbitration rules.
module tb_wrr_bank_scheduler;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    wrr_bank_scheduler_if #(.NPORTS(1)) if1 ();
    wrr_bank_scheduler_if #(.NPORTS(2)) if2 ();

    wrr_bank_scheduler #(.NPORTS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    wrr_bank_scheduler #(.NPORTS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] pk(input logic we, input logic [2:0] la,
                                       input logic [7:0] v);
        return {1'b1, we, la, v};
    endfunction

    task automatic clear_all();
        if1.req_valid  = '0;
        if1.req_addr   = '0;
        if1.req_value  = '0;
        if1.req_we     = '0;
        if1.bank_stall = '0;
        if2.req_valid  = '0;
        if2.req_addr   = '0;
        if2.req_value  = '0;
        if2.req_we     = '0;
        if2.bank_stall = '0;
        for (int c = 0; c < 4; c++) begin
            if1.weight[c] = 4'd1;
            if2.weight[c] = 4'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_all();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic req1(input int c, input logic [3:0] a,
                        input logic [7:0] v, input logic we);
        if1.req_valid[c] = 1'b1;
        if1.req_addr[c]  = a;
        if1.req_value[c] = v;
        if1.req_we[c]    = we;
    endtask

    int seq35[5]  = '{0, 1, 2, 3, 0};
    int seq36[11] = '{0, 0, -1, 0, 1, 2, 3, 0, 0, 0, 1};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clear_all();

        // Reset held with every consumer requesting bank 0
        for (int c = 0; c < 4; c++) req1(c, 4'(2 * c), 8'(16 + c), 1'b0);
        @(negedge clk);
        #1;
        chk("rst_ready", 64'(if1.req_ready), 64'h0);
        chk("rst_out", 64'(if1.out), 64'h0);
        chk("rst_id", 64'(if1.out_id), 64'h0);
        @(posedge clk);
        #1;
        chk("rst_out_edge", 64'(if1.out), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_ready", 64'(if1.req_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("rel_out", 64'(if1.out[0]), 64'(pk(1'b0, 3'd0, 8'h10)));

        // Single consumer 1, write to bank 1
        do_reset();
        req1(1, 4'h5, 8'hAA, 1'b1);
        #1;
        chk("single_ready", 64'(if1.req_ready), 64'h2);
        @(posedge clk);
        #1;
        chk("single_out1", 64'(if1.out[1]), 64'h1AAA);
        chk("single_id1", 64'(if1.out_id[1]), 64'h1);
        chk("single_out0", 64'(if1.out[0]), 64'h0);
        @(negedge clk);
        if1.req_valid = '0;
        @(posedge clk);
        #1;
        chk("single_idle", 64'(if1.out[1][12]), 64'h0);

        // Equal weights, all on bank 0
        do_reset();
        for (int c = 0; c < 4; c++) req1(c, 4'(2 * c), 8'(16 + c), 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_ready", 64'(if1.req_ready), 64'(32'd1 << seq35[i]));
            @(posedge clk);
            #1;
            chk("rr_out", 64'(if1.out[0]),
                64'(pk(1'b0, 3'(seq35[i]), 8'(16 + seq35[i]))));
            chk("rr_id", 64'(if1.out_id[0]), 64'(seq35[i]));
            @(negedge clk);
        end

        // Weight 3 on consumer 0, with a one-cycle stall
        do_reset();
        if1.weight[0] = 4'd3;
        for (int c = 0; c < 4; c++) req1(c, 4'(2 * c), 8'(16 + c), 1'b0);
        for (int i = 0; i < 11; i++) begin
            if1.bank_stall[0] = (seq36[i] < 0);
            #1;
            chk("wrr_ready", 64'(if1.req_ready),
                (seq36[i] < 0) ? 64'h0 : 64'(32'd1 << seq36[i]));
            @(posedge clk);
            #1;
            if (seq36[i] < 0)
                chk("wrr_stall_v", 64'(if1.out[0][12]), 64'h0);
            else
                chk("wrr_id", 64'(if1.out_id[0]), 64'(seq36[i]));
            @(negedge clk);
        end
        if1.bank_stall = '0;

        // Two banks in parallel
        do_reset();
        for (int c = 0; c < 4; c++) req1(c, 4'(c), 8'(16 + c), 1'b1);
        #1;
        chk("par_ready0", 64'(if1.req_ready), 64'h3);
        @(posedge clk);
        #1;
        chk("par_id0", 64'(if1.out_id), 64'h4);
        @(negedge clk);
        #1;
        chk("par_ready1", 64'(if1.req_ready), 64'hC);
        @(posedge clk);
        #1;
        chk("par_id1", 64'(if1.out_id), 64'hE);
        chk("par_out1", 64'(if1.out[1]), 64'(pk(1'b1, 3'd1, 8'h13)));

        // Two ports per bank, then asynchronous reset mid-stream
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if2.req_valid[c] = 1'b1;
            if2.req_addr[c]  = 4'(2 * c);
            if2.req_value[c] = 8'(32 + c);
        end
        #1;
        chk("p2_ready0", 64'(if2.req_ready), 64'h3);
        @(posedge clk);
        #1;
        chk("p2_id0", 64'(if2.out_id[0]), 64'h0);
        chk("p2_id1", 64'(if2.out_id[1]), 64'h1);
        chk("p2_out1", 64'(if2.out[1]), 64'(pk(1'b0, 3'd1, 8'h21)));
        @(negedge clk);
        #1;
        chk("p2_ready1", 64'(if2.req_ready), 64'h5);
        @(posedge clk);
        #1;
        chk("p2_id2", 64'(if2.out_id[0]), 64'h2);
        chk("p2_id3", 64'(if2.out_id[1]), 64'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("p2_arst_v0", 64'(if2.out[0][12]), 64'h0);
        chk("p2_arst_v1", 64'(if2.out[1][12]), 64'h0);
        chk("p2_arst_rdy", 64'(if2.req_ready), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
